// File: rtl/rs232_tx_if.sv
// rs232_tx_if: byte-write handshake plus status and serial line of rs232_tx.
// The master side writes bytes; the slave side is the transmitter itself.
interface rs232_tx_if;
  logic       tx_start;
  logic [7:0] tx_datain;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_transmitter;

  modport master (
    output tx_start,
    output tx_datain,
    input  tx_ready,
    input  tx_busy,
    input  tx_done,
    input  tx_transmitter
  );

  modport slave (
    input  tx_start,
    input  tx_datain,
    output tx_ready,
    output tx_busy,
    output tx_done,
    output tx_transmitter
  );
endinterface

// File: rtl/rs232_tx.sv
// rs232_tx: 8N1 serial transmitter with a one-entry holding register.
// Bit timing comes from a fractional baud accumulator whose carry is the tick.
// Optional feature macro: RS232_TX_PARITY_EN adds an even-parity bit after D7.
module rs232_tx #(
  parameter int CLOCK_FREQ     = 100000000,
  parameter int BAUD_RATE      = 115200,
  parameter int BAUD_ACC_WIDTH = 16
) (
  input logic       clock,
  input logic       reset_neg,
  input logic       Exe_LogicImp,
  rs232_tx_if.slave tx_bus
);

  localparam longint INCR_CALC =
    ((longint'(BAUD_RATE) << (BAUD_ACC_WIDTH - 4)) + (longint'(CLOCK_FREQ) >> 5)) /
    (longint'(CLOCK_FREQ) >> 4);
  localparam logic [BAUD_ACC_WIDTH:0] INCR = INCR_CALC[BAUD_ACC_WIDTH:0];

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    START  = 4'd1,
    D0     = 4'd2,
    D1     = 4'd3,
    D2     = 4'd4,
    D3     = 4'd5,
    D4     = 4'd6,
    D5     = 4'd7,
    D6     = 4'd8,
    D7     = 4'd9,
`ifdef RS232_TX_PARITY_EN
    PARITY = 4'd10,
`endif
    STOP   = 4'd11
  } state_t;

  state_t                  state_q;
  state_t                  state_next;
  logic [BAUD_ACC_WIDTH:0] acc_q;
  logic                    tick;
  logic [7:0]              hold_q;
  logic                    hold_full_q;
  logic [7:0]              shift_q;
  logic                    line_q;
  logic                    line_next;
  logic                    done_q;
  logic                    done_next;
  logic                    load;
  logic                    shift_en;
`ifdef RS232_TX_PARITY_EN
  logic                    parity_q;
`endif

  // The accumulator carry marks the end of each bit period.
  assign tick = acc_q[BAUD_ACC_WIDTH];

  assign tx_bus.tx_ready       = ~hold_full_q;
  assign tx_bus.tx_busy        = (state_q != IDLE);
  assign tx_bus.tx_done        = done_q;
  assign tx_bus.tx_transmitter = line_q;

  // Next-state decode; the line value is chosen from the state being entered so the output flop never glitches.
  always_comb begin
    state_next = state_q;
    line_next  = line_q;
    done_next  = 1'b0;
    load       = 1'b0;
    shift_en   = 1'b0;
    case (state_q)
      IDLE: begin
        line_next = 1'b1;
        if (hold_full_q) begin
          state_next = START;
          load       = 1'b1;
          line_next  = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_next = D0;
          line_next  = shift_q[0];
        end
      end
      D0, D1, D2, D3, D4, D5, D6: begin
        if (tick) begin
          state_next = state_t'(state_q + 4'd1);
          line_next  = shift_q[1];
          shift_en   = 1'b1;
        end
      end
      D7: begin
        if (tick) begin
`ifdef RS232_TX_PARITY_EN
          state_next = PARITY;
          line_next  = parity_q;
`else
          state_next = STOP;
          line_next  = 1'b1;
`endif
        end
      end
`ifdef RS232_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_next = STOP;
          line_next  = 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          done_next = 1'b1;
          if (hold_full_q) begin
            state_next = START;
            load       = 1'b1;
            line_next  = 1'b0;
          end else begin
            state_next = IDLE;
            line_next  = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        line_next  = 1'b1;
      end
    endcase
  end

  // State, serial line and done pulse registers; the synchronous clear aborts any frame.
  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      state_q <= IDLE;
      line_q  <= 1'b1;
      done_q  <= 1'b0;
    end else if (Exe_LogicImp) begin
      state_q <= IDLE;
      line_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_next;
      line_q  <= line_next;
      done_q  <= done_next;
    end
  end

  // Baud accumulator: parked at zero in IDLE and restarted on every frame load so the start bit is aligned.
  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      acc_q <= '0;
    end else if (Exe_LogicImp) begin
      acc_q <= '0;
    end else if (load || (state_next == IDLE)) begin
      acc_q <= '0;
    end else begin
      acc_q <= {1'b0, acc_q[BAUD_ACC_WIDTH-1:0]} + INCR;
    end
  end

  // Holding register: accepts a byte only while empty, drained when a frame loads.
  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
    end else if (Exe_LogicImp) begin
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
    end else if (tx_bus.tx_start && !hold_full_q) begin
      hold_q      <= tx_bus.tx_datain;
      hold_full_q <= 1'b1;
    end else if (load) begin
      hold_full_q <= 1'b0;
    end
  end

`ifdef RS232_TX_PARITY_EN
  // Shift register (LSB first) plus the even-parity bit captured when the frame loads.
  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      shift_q  <= 8'h00;
      parity_q <= 1'b0;
    end else if (Exe_LogicImp) begin
      shift_q  <= 8'h00;
      parity_q <= 1'b0;
    end else if (load) begin
      shift_q  <= hold_q;
      parity_q <= ^hold_q;
    end else if (shift_en) begin
      shift_q  <= {1'b0, shift_q[7:1]};
    end
  end
`else
  // Shift register (LSB first), loaded from the holding register at each frame start.
  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      shift_q <= 8'h00;
    end else if (Exe_LogicImp) begin
      shift_q <= 8'h00;
    end else if (load) begin
      shift_q <= hold_q;
    end else if (shift_en) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end
  end
`endif

endmodule

// File: tb/tb_rs232_tx.sv
// tb_rs232_tx: self-checking bench for rs232_tx.
// The reference model predicts each bit boundary from the baud arithmetic
// (k-th carry after a load happens ceil(k*2^W/Incr) cycles later) and the
// frame contents from the byte, independent of the design's state machine.
module tb_rs232_tx;
  localparam int CLOCK_FREQ     = 100000000;
  localparam int BAUD_RATE      = 115200;
  localparam int BAUD_ACC_WIDTH = 16;
  localparam longint INCR =
    ((longint'(BAUD_RATE) << (BAUD_ACC_WIDTH - 4)) + (longint'(CLOCK_FREQ) >> 5)) /
    (longint'(CLOCK_FREQ) >> 4);
  localparam longint ACC_SPAN = longint'(1) << BAUD_ACC_WIDTH;
`ifdef RS232_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam bit PARITY_ON  = 1'b1;
`else
  localparam int FRAME_BITS = 10;
  localparam bit PARITY_ON  = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       parity;
  } vec_t;

  logic clock        = 1'b0;
  logic reset_neg    = 1'b0;
  logic Exe_LogicImp = 1'b0;

  int cyc       = 0;
  int doneCount = 0;
  int tests     = 0;
  int failed    = 0;

  rs232_tx_if bus ();

  rs232_tx #(
    .CLOCK_FREQ    (CLOCK_FREQ),
    .BAUD_RATE     (BAUD_RATE),
    .BAUD_ACC_WIDTH(BAUD_ACC_WIDTH)
  ) dut (
    .clock       (clock),
    .reset_neg   (reset_neg),
    .Exe_LogicImp(Exe_LogicImp),
    .tx_bus      (bus)
  );

  always #5 clock = ~clock;

  // Edge counter and count of cycles in which tx_done was high.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.tx_done === 1'b1) doneCount <= doneCount + 1;
  end

  // Safety net so the run always ends.
  initial begin
    #1000000;
    failed++;
    $display("[TB] FAIL watchdog: actual timeout, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1, "[TB] watchdog");
  end

  function automatic int bitEdge(input int loadEdge, input int k);
    longint n;
    if (k == 0) return loadEdge;
    n = (longint'(k) * ACC_SPAN + INCR - 1) / INCR;
    return loadEdge + 1 + int'(n);
  endfunction

  function automatic logic evenParity(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    return logic'(ones % 2);
  endfunction

  function automatic logic [10:0] frameBits(input logic [7:0] d, input logic p);
    logic [10:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9] = PARITY_ON ? p : 1'b1;
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: actual %0h, required %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [7:0] data);
    bus.tx_start  = start;
    bus.tx_datain = data;
    @(negedge clock);
    bus.tx_start  = 1'b0;
  endtask

  task automatic waitEdge(input int e);
    while (cyc < e) @(negedge clock);
  endtask

  task automatic checkFrame(input string tag, input logic [7:0] data, input logic p,
                            input int loadEdge, input bit followed, output int endEdge);
    logic [10:0] f;
    int b0;
    int b1;
    f = frameBits(data, p);
    for (int k = 0; k < FRAME_BITS; k++) begin
      b0 = bitEdge(loadEdge, k);
      b1 = bitEdge(loadEdge, k + 1);
      waitEdge(b0);
      checkOutput($sformatf("%s bit%0d first", tag, k), bus.tx_transmitter, f[k]);
      checkOutput($sformatf("%s busy bit%0d", tag, k), bus.tx_busy, 1'b1);
      waitEdge(b1 - 1);
      checkOutput($sformatf("%s bit%0d last", tag, k), bus.tx_transmitter, f[k]);
      checkOutput($sformatf("%s done low bit%0d", tag, k), bus.tx_done, 1'b0);
    end
    endEdge = bitEdge(loadEdge, FRAME_BITS);
    waitEdge(endEdge);
    checkOutput($sformatf("%s done pulse", tag), bus.tx_done, 1'b1);
    checkOutput($sformatf("%s line after stop", tag), bus.tx_transmitter, followed ? 1'b0 : 1'b1);
    if (!followed) begin
      waitEdge(endEdge + 1);
      checkOutput($sformatf("%s done cleared", tag), bus.tx_done, 1'b0);
      checkOutput($sformatf("%s busy cleared", tag), bus.tx_busy, 1'b0);
    end
  endtask

  initial begin
    vec_t       vecs[3];
    int         ld;
    int         ld2;
    int         e1;
    int         e2;
    int         base;
    logic [7:0] r;

    vecs[0] = '{data: 8'h55, parity: 1'b0};
    vecs[1] = '{data: 8'h07, parity: 1'b1};
    vecs[2] = '{data: 8'h03, parity: 1'b0};

    bus.tx_start  = 1'b0;
    bus.tx_datain = 8'h00;

    // Reset values while held in reset.
    #23;
    checkOutput("reset line", bus.tx_transmitter, 1'b1);
    checkOutput("reset ready", bus.tx_ready, 1'b1);
    checkOutput("reset busy", bus.tx_busy, 1'b0);
    checkOutput("reset done", bus.tx_done, 1'b0);
    @(negedge clock);
    reset_neg = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("idle line", bus.tx_transmitter, 1'b1);
    checkOutput("idle busy", bus.tx_busy, 1'b0);

    // Table of single frames.
    for (int i = 0; i < 3; i++) begin
      base = doneCount;
      applyStimulus(1'b1, vecs[i].data);
      ld = cyc + 1;
      checkOutput($sformatf("v%0d ready after write", i), bus.tx_ready, 1'b0);
      checkOutput($sformatf("v%0d line high one edge", i), bus.tx_transmitter, 1'b1);
      checkFrame($sformatf("v%0d", i), vecs[i].data, vecs[i].parity, ld, 1'b0, e1);
      repeat (5) @(negedge clock);
      checkOutput($sformatf("v%0d done count", i), doneCount - base, 1);
    end

    // Back-to-back frames with a third write that must be ignored.
    base = doneCount;
    applyStimulus(1'b1, 8'hA3);
    ld = cyc + 1;
    @(negedge clock);
    checkOutput("b2b start low", bus.tx_transmitter, 1'b0);
    checkOutput("b2b ready after drain", bus.tx_ready, 1'b1);
    applyStimulus(1'b1, 8'h0F);
    checkOutput("b2b ready held", bus.tx_ready, 1'b0);
    applyStimulus(1'b1, 8'hFF);
    checkOutput("b2b ready still held", bus.tx_ready, 1'b0);
    checkFrame("A3", 8'hA3, 1'b0, ld, 1'b1, e1);
    checkFrame("0F", 8'h0F, 1'b0, e1, 1'b0, e2);
    repeat (5) @(negedge clock);
    checkOutput("b2b done count", doneCount - base, 2);
    checkOutput("b2b ready end", bus.tx_ready, 1'b1);
    checkOutput("b2b busy end", bus.tx_busy, 1'b0);

    // Synchronous clear during D3, colliding with a write.
    base = doneCount;
    r = 8'hC4;
    applyStimulus(1'b1, r);
    ld = cyc + 1;
    waitEdge(bitEdge(ld, 4) + 20);
    checkOutput("C4 in D3", bus.tx_transmitter, r[3]);
    Exe_LogicImp  = 1'b1;
    bus.tx_start  = 1'b1;
    bus.tx_datain = 8'h12;
    @(negedge clock);
    Exe_LogicImp = 1'b0;
    bus.tx_start = 1'b0;
    checkOutput("abort line", bus.tx_transmitter, 1'b1);
    checkOutput("abort busy", bus.tx_busy, 1'b0);
    checkOutput("abort ready", bus.tx_ready, 1'b1);
    checkOutput("abort done", bus.tx_done, 1'b0);
    repeat (50) @(negedge clock);
    checkOutput("abort stays idle", bus.tx_busy, 1'b0);
    checkOutput("abort no done", doneCount - base, 0);
    applyStimulus(1'b1, 8'h12);
    ld = cyc + 1;
    checkFrame("12", 8'h12, 1'b0, ld, 1'b0, e1);

    // Asynchronous reset at a random point of a random frame.
    base = doneCount;
    r = 8'($urandom);
    applyStimulus(1'b1, r);
    ld = cyc + 1;
    waitEdge(ld + int'($urandom_range(100, 3000)));
    #2;
    reset_neg = 1'b0;
    #1;
    checkOutput("async reset line", bus.tx_transmitter, 1'b1);
    checkOutput("async reset ready", bus.tx_ready, 1'b1);
    checkOutput("async reset busy", bus.tx_busy, 1'b0);
    checkOutput("async reset done", bus.tx_done, 1'b0);
    @(negedge clock);
    #3;
    reset_neg = 1'b1;
    repeat (20) @(negedge clock);
    checkOutput("post reset line", bus.tx_transmitter, 1'b1);
    checkOutput("post reset busy", bus.tx_busy, 1'b0);
    checkOutput("post reset ready", bus.tx_ready, 1'b1);
    checkOutput("post reset no done", doneCount - base, 0);

    // Random byte after a random gap.
    base = doneCount;
    r = 8'($urandom);
    repeat ($urandom_range(1, 7)) @(negedge clock);
    applyStimulus(1'b1, r);
    ld2 = cyc + 1;
    checkFrame($sformatf("rand %02h", r), r, evenParity(r), ld2, 1'b0, e1);
    repeat (5) @(negedge clock);
    checkOutput("rand done count", doneCount - base, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
